// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing the memory-side bus between icache and dcache.
// Holds the grant for a whole transaction: request beats, then response beats.
module cache_bus_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int TAG_WIDTH  = 13,
   parameter int LINE_BEATS = 8
) (
   input  logic                  clk,
   input  logic                  reset,

   input  logic [DATA_WIDTH-1:0] ic_req,
   input  logic [TAG_WIDTH-1:0]  ic_reqtag,
   input  logic                  ic_reqcyc,
   output logic                  ic_reqack,
   output logic [DATA_WIDTH-1:0] ic_resp,
   output logic [TAG_WIDTH-1:0]  ic_resptag,
   output logic                  ic_respcyc,
   input  logic                  ic_respack,

   input  logic [DATA_WIDTH-1:0] dc_req,
   input  logic [TAG_WIDTH-1:0]  dc_reqtag,
   input  logic                  dc_reqcyc,
   output logic                  dc_reqack,
   output logic [DATA_WIDTH-1:0] dc_resp,
   output logic [TAG_WIDTH-1:0]  dc_resptag,
   output logic                  dc_respcyc,
   input  logic                  dc_respack,

   output logic [DATA_WIDTH-1:0] mem_req,
   output logic [TAG_WIDTH-1:0]  mem_reqtag,
   output logic                  mem_reqcyc,
   input  logic                  mem_reqack,
   input  logic [DATA_WIDTH-1:0] mem_resp,
   input  logic [TAG_WIDTH-1:0]  mem_resptag,
   input  logic                  mem_respcyc,
   output logic                  mem_respack
);

   localparam int BW = $clog2(LINE_BEATS + 1);
   localparam logic [3:0] TYPE_MEM = 4'b0001;

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
   typedef enum logic {IC = 1'b0, DC = 1'b1} req_t;

   state_t          state;
   req_t            grant;
   req_t            last_grant;
   logic            is_read;
   logic [BW-1:0]   beats_left;

   logic                 pick_dc;
   logic [TAG_WIDTH-1:0] new_tag;
   logic [BW-1:0]        new_beats;
   logic                 in_req;
   logic                 in_resp;
   logic                 req_beat;
   logic                 last_beat;
   logic                 to_dc;
   logic                 to_ic;

   // On a tie the requester that did not win last time gets the bus.
   always_comb begin
      pick_dc = dc_reqcyc & (~ic_reqcyc | (last_grant == IC));
      new_tag = pick_dc ? dc_reqtag : ic_reqtag;
      new_beats = BW'(2);
      if (new_tag[12])
         new_beats = BW'(1);
      else if (new_tag[11:8] == TYPE_MEM)
         new_beats = BW'(LINE_BEATS + 1);
   end

   assign in_req    = (state == REQ);
   assign in_resp   = (state == RESP);
   assign to_dc     = (grant == DC);
   assign to_ic     = (grant == IC);
   assign last_beat = (beats_left == BW'(1));

   assign mem_req    = in_req ? (to_dc ? dc_req : ic_req) : '0;
   assign mem_reqtag = in_req ? (to_dc ? dc_reqtag : ic_reqtag) : '0;
   assign mem_reqcyc = in_req & (to_dc ? dc_reqcyc : ic_reqcyc);
   assign req_beat   = mem_reqcyc & mem_reqack;

   assign ic_reqack = req_beat & to_ic;
   assign dc_reqack = req_beat & to_dc;

   assign ic_resp    = (in_resp & to_ic) ? mem_resp : '0;
   assign ic_resptag = (in_resp & to_ic) ? mem_resptag : '0;
   assign ic_respcyc = in_resp & to_ic & mem_respcyc;
   assign dc_resp    = (in_resp & to_dc) ? mem_resp : '0;
   assign dc_resptag = (in_resp & to_dc) ? mem_resptag : '0;
   assign dc_respcyc = in_resp & to_dc & mem_respcyc;

   assign mem_respack = in_resp & mem_respcyc
                      & (to_dc ? dc_respack : ic_respack);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= IC;
         last_grant <= IC;
         is_read    <= 1'b0;
         beats_left <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ic_reqcyc | dc_reqcyc) begin
                  grant      <= req_t'(pick_dc);
                  last_grant <= req_t'(pick_dc);
                  is_read    <= new_tag[12];
                  beats_left <= new_beats;
                  state      <= REQ;
               end
            end
            REQ: begin
               if (req_beat) begin
                  if (!last_beat) begin
                     beats_left <= beats_left - BW'(1);
                  end else if (is_read) begin
                     // Tag is still held on the bus during its final beat.
                     beats_left <= (mem_reqtag[11:8] == TYPE_MEM)
                                 ? BW'(LINE_BEATS) : BW'(1);
                     state      <= RESP;
                  end else begin
                     beats_left <= '0;
                     state      <= IDLE;
                  end
               end
            end
            RESP: begin
               if (mem_respack) begin
                  beats_left <= beats_left - BW'(1);
                  if (last_beat)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized bench for cache_bus_arbiter against a transaction-level model.
// The bench plays both cache controllers and the memory side.
module tb_cache_bus_arbiter;

   localparam int DW = 64;
   localparam int TW = 13;
   localparam int LB = 8;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [1:0][DW-1:0] rq_req;
   logic [1:0][TW-1:0] rq_tag;
   logic [1:0]         rq_cyc;
   logic [1:0]         rq_rack;
   logic [1:0][DW-1:0] o_resp;
   logic [1:0][TW-1:0] o_rtag;
   logic [1:0]         o_rcyc;
   logic [1:0]         o_ack;

   logic [DW-1:0] mem_req;
   logic [TW-1:0] mem_reqtag;
   logic          mem_reqcyc;
   logic          mem_reqack;
   logic [DW-1:0] mem_resp;
   logic [TW-1:0] mem_resptag;
   logic          mem_respcyc;
   logic          mem_respack;

   cache_bus_arbiter #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .LINE_BEATS(LB)) dut (
      .clk(clk), .reset(reset),
      .ic_req(rq_req[0]), .ic_reqtag(rq_tag[0]), .ic_reqcyc(rq_cyc[0]),
      .ic_reqack(o_ack[0]), .ic_resp(o_resp[0]), .ic_resptag(o_rtag[0]),
      .ic_respcyc(o_rcyc[0]), .ic_respack(rq_rack[0]),
      .dc_req(rq_req[1]), .dc_reqtag(rq_tag[1]), .dc_reqcyc(rq_cyc[1]),
      .dc_reqack(o_ack[1]), .dc_resp(o_resp[1]), .dc_resptag(o_rtag[1]),
      .dc_respcyc(o_rcyc[1]), .dc_respack(rq_rack[1]),
      .mem_req(mem_req), .mem_reqtag(mem_reqtag), .mem_reqcyc(mem_reqcyc),
      .mem_reqack(mem_reqack), .mem_resp(mem_resp),
      .mem_resptag(mem_resptag), .mem_respcyc(mem_respcyc),
      .mem_respack(mem_respack)
   );

   int checks = 0;
   int errors = 0;

   logic [1:0][55:0] salt;
   logic [1:0]       pend;
   int               last;

   task automatic check(input string name, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [63:0] req_data(input int w, input int beat);
      return {salt[w], 8'(beat)};
   endfunction

   function automatic logic [12:0] rand_tag(input int w);
      logic [3:0] ty;
      case ($urandom_range(0, 3))
         0:       ty = 4'b0001;
         1:       ty = 4'b0011;
         2:       ty = 4'b0100;
         default: ty = 4'b1110;
      endcase
      return {1'($urandom_range(0, 1)), ty, 7'd0, 1'(w == 0)};
   endfunction

   task automatic raise(input int w, input logic [12:0] tag);
      logic [63:0] r;
      r = {$urandom, $urandom};
      salt[w]   = r[55:0];
      rq_tag[w] = tag;
      rq_req[w] = req_data(w, 0);
      rq_cyc[w] = 1'b1;
      pend[w]   = 1'b1;
   endtask

   task automatic all_zero(input string name);
      check({name, "_ctl"}, {mem_reqcyc, mem_respack, o_rcyc, o_ack}, 0);
      check({name, "_data"}, mem_req | o_resp[0] | o_resp[1], 0);
      check({name, "_tag"}, 64'(mem_reqtag | o_rtag[0] | o_rtag[1]), 0);
   endtask

   // Entered just before the IDLE cycle in which w is expected to win.
   task automatic do_txn(input int w, input int abort_beat,
                         input int stall_beat);
      int o, nreq, nresp, beat, r, guard, stall_cnt;
      logic [12:0] tag;
      logic rd, mm;
      o     = 1 - w;
      tag   = rq_tag[w];
      rd    = tag[12];
      mm    = (tag[11:8] == 4'b0001);
      nreq  = rd ? 1 : (mm ? LB + 1 : 2);
      nresp = rd ? (mm ? LB : 1) : 0;

      @(negedge clk);
      mem_respcyc = 1'b1;
      mem_resp    = 64'hdead;
      mem_reqack  = 1'($urandom);
      rq_rack     = '1;
      #1;
      all_zero("idle");

      beat  = 0;
      guard = 0;
      while (beat < nreq) begin
         @(negedge clk);
         mem_respcyc = 1'b0;
         mem_reqack  = 1'($urandom);
         rq_req[w]   = req_data(w, beat);
         #1;
         check("req_cyc", mem_reqcyc, 1);
         check("req_tag", mem_reqtag, tag);
         check("req_data", mem_req, req_data(w, beat));
         check("req_ack", o_ack[w], mem_reqack);
         check("req_ack_other", o_ack[o], 0);
         check("req_no_resp", {mem_respack, o_rcyc}, 0);
         if (mem_reqack) beat++;
         if (++guard > 200) begin
            check("req_timeout", 1, 0);
            break;
         end
      end
      @(posedge clk);
      #1;
      rq_cyc[w] = 1'b0;

      r         = 0;
      guard     = 0;
      stall_cnt = 0;
      while (r < nresp) begin
         @(negedge clk);
         mem_reqack  = 1'($urandom);
         mem_resp    = 64'hA0 + 64'(r);
         mem_resptag = 13'($urandom);
         if (stall_beat == r + 1 && stall_cnt < 5) begin
            mem_respcyc = 1'b1;
            rq_rack[w]  = 1'b0;
            stall_cnt++;
         end else begin
            mem_respcyc = ($urandom_range(0, 3) != 0);
            rq_rack[w]  = ($urandom_range(0, 3) != 0);
         end
         #1;
         check("resp_data", o_resp[w], 64'hA0 + 64'(r));
         check("resp_tag", o_rtag[w], mem_resptag);
         check("resp_cyc", o_rcyc[w], mem_respcyc);
         check("resp_ack", mem_respack, mem_respcyc & rq_rack[w]);
         check("resp_other", {o_rcyc[o], o_ack[o], mem_reqcyc}, 0);
         check("resp_other_data", o_resp[o], 0);
         if (abort_beat == r + 1) begin
            reset = 1'b0;
            #1;
            all_zero("abort");
            mem_respcyc = 1'b0;
            rq_cyc      = '0;
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         if (mem_respcyc && rq_rack[w]) r++;
         if (++guard > 300) begin
            check("resp_timeout", 1, 0);
            break;
         end
      end
   endtask

   task automatic serve(input int abort_beat, input int stall_beat);
      int w;
      w = (pend == 2'b11) ? 1 - last : (pend[1] ? 1 : 0);
      do_txn(w, abort_beat, stall_beat);
      last    = w;
      pend[w] = 1'b0;
      if (abort_beat != 0) begin
         last = 0;
         pend = '0;
      end
   endtask

   initial begin
      rq_req = '0; rq_tag = '0; rq_cyc = '0; rq_rack = '0;
      mem_reqack = 1'b0; mem_resp = '0; mem_resptag = '0;
      mem_respcyc = 1'b0; pend = '0; last = 0; salt = '0;

      repeat (3) @(negedge clk);
      mem_respcyc = 1'b1; mem_reqack = 1'b1; mem_resp = 64'h55;
      mem_resptag = 13'h1fff; rq_rack = '1;
      #1;
      all_zero("reset");
      mem_respcyc = 1'b0; mem_reqack = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      raise(1, 13'h1100);
      serve(0, 0);

      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      last  = 0;
      @(posedge clk);
      #1;
      raise(0, 13'h1301);
      raise(1, 13'h0100);
      serve(0, 0);
      serve(0, 0);

      raise(1, 13'h1100);
      serve(0, 3);

      raise(1, 13'h1100);
      serve(4, 0);
      @(posedge clk);
      #1;
      raise(0, 13'h1101);
      serve(0, 0);

      for (int i = 0; i < 60; i++) begin
         if (!pend[0] && $urandom_range(0, 2) == 0) raise(0, rand_tag(0));
         if (!pend[1] && $urandom_range(0, 2) == 0) raise(1, rand_tag(1));
         if (pend == 2'b00) begin
            if ($urandom_range(0, 1) == 1) raise(1, rand_tag(1));
            else raise(0, rand_tag(0));
         end
         serve(0, 0);
      end
      while (pend != 2'b00) serve(0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
